accel_loader: RTL and testbench



---
 rtl/accel_loader.sv | 192 +++++++++++++++++++
 tb/tb_accel_loader.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/accel_loader.sv
// accel_loader
// ------------
// Host-side loader for the accelerator's two random-write register files.
// It takes a valid/ready word stream framed as
//   header (N-1 in the low ADDR_W bits), then N pairs of (InexRecur word, state word)
// and writes pair k to address k of both files. Each write appears one cycle after
// its word is accepted. It then raises is_start and holds it until acc_done_i.
//
// Optional build macro: LOAD_CHECKSUM_EN
//   When defined, one extra word follows the last pair. It must equal the XOR of
//   every frame word, header included. On a mismatch err_o is set and the loader
//   returns to idle without starting the accelerator. Data already written stays
//   in the register files.
//
// Handshake: a word transfers on a rising clk edge where in_valid && in_ready.
//   in_valid may drop at any time; the loader then waits in place. in_ready does
//   not depend on in_valid.
//
// Ports
//   clk, rst                       clock, synchronous active-high reset
//   in_valid / in_ready / in_data  32-bit input word stream
//   acc_done_i                     one-cycle completion pulse from the accelerator
//   ran_we_InexRecur / ran_w_addr_InexRecur / ran_w_data_InexRecur   InexRecur write port
//   ran_we_state / ran_w_addr_state / ran_w_data_state                state write port
//   is_start                       accelerator run enable
//   busy_o                         high whenever the loader is not idle
//   err_o                          sticky frame-format error, cleared by the next header
module accel_loader #(
    parameter int ADDR_W = 12,
    parameter int IR_W   = 32,
    parameter int ST_W   = 18
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_data,
    input  logic              acc_done_i,
    output logic              ran_we_InexRecur,
    output logic [ADDR_W-1:0] ran_w_addr_InexRecur,
    output logic [IR_W-1:0]   ran_w_data_InexRecur,
    output logic              ran_we_state,
    output logic [ADDR_W-1:0] ran_w_addr_state,
    output logic [ST_W-1:0]   ran_w_data_state,
    output logic              is_start,
    output logic              busy_o,
    output logic              err_o
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LD_IR = 3'd1,
        S_LD_ST = 3'd2,
        S_CHK   = 3'd3,
        S_GAP   = 3'd4,
        S_RUN   = 3'd5
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic                w_in_ready;
    logic                w_accept;
    logic [ADDR_W-1:0]   r_idx;
    logic [ADDR_W-1:0]   r_last;
    logic                r_err;
    logic                r_start;
    logic                r_we_ir;
    logic [ADDR_W-1:0]   r_addr_ir;
    logic [IR_W-1:0]     r_data_ir;
    logic                r_we_st;
    logic [ADDR_W-1:0]   r_addr_st;
    logic [ST_W-1:0]     r_data_st;
`ifdef LOAD_CHECKSUM_EN
    logic [31:0]         r_chk;
`endif

    // Next state and in_ready. in_valid is used directly, not w_accept, so this
    // block never depends on its own output.
    always_comb begin
        w_next     = r_state;
        w_in_ready = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_in_ready = 1'b1;
                if (in_valid) w_next = S_LD_IR;
            end
            S_LD_IR: begin
                w_in_ready = 1'b1;
                if (in_valid) w_next = S_LD_ST;
            end
            S_LD_ST: begin
                w_in_ready = 1'b1;
                if (in_valid) begin
                    if (r_idx == r_last) begin
`ifdef LOAD_CHECKSUM_EN
                        w_next = S_CHK;
`else
                        w_next = S_GAP;
`endif
                    end else begin
                        w_next = S_LD_IR;
                    end
                end
            end
`ifdef LOAD_CHECKSUM_EN
            S_CHK: begin
                w_in_ready = 1'b1;
                if (in_valid) w_next = (in_data == r_chk) ? S_GAP : S_IDLE;
            end
`endif
            // The final state write is on the port during GAP. is_start therefore
            // rises only after that write has landed.
            S_GAP:   w_next = S_RUN;
            S_RUN:   if (acc_done_i) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    assign w_accept = in_valid & w_in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_idx     <= '0;
            r_last    <= '0;
            r_err     <= 1'b0;
            r_start   <= 1'b0;
            r_we_ir   <= 1'b0;
            r_addr_ir <= '0;
            r_data_ir <= '0;
            r_we_st   <= 1'b0;
            r_addr_st <= '0;
            r_data_st <= '0;
`ifdef LOAD_CHECKSUM_EN
            r_chk     <= '0;
`endif
        end else begin
            r_state <= w_next;
            r_we_ir <= 1'b0;
            r_we_st <= 1'b0;
            // Registered copy of "RUN next cycle". This is cycle-equivalent to
            // decoding S_RUN, but drives is_start straight from a flop.
            r_start <= (w_next == S_RUN);
            case (r_state)
                S_IDLE: if (w_accept) begin
                    r_last <= in_data[ADDR_W-1:0];
                    r_idx  <= '0;
                    r_err  <= |in_data[31:ADDR_W];
`ifdef LOAD_CHECKSUM_EN
                    r_chk  <= in_data;
`endif
                end
                S_LD_IR: if (w_accept) begin
                    r_we_ir   <= 1'b1;
                    r_addr_ir <= r_idx;
                    r_data_ir <= in_data[IR_W-1:0];
`ifdef LOAD_CHECKSUM_EN
                    r_chk     <= r_chk ^ in_data;
`endif
                end
                S_LD_ST: if (w_accept) begin
                    r_we_st   <= 1'b1;
                    r_addr_st <= r_idx;
                    r_data_st <= in_data[ST_W-1:0];
                    if (|in_data[31:ST_W]) r_err <= 1'b1;
                    // The index stops at the last entry, so an N=2**ADDR_W frame
                    // never wraps the index.
                    if (r_idx != r_last) r_idx <= r_idx + ADDR_W'(1);
`ifdef LOAD_CHECKSUM_EN
                    r_chk     <= r_chk ^ in_data;
`endif
                end
`ifdef LOAD_CHECKSUM_EN
                S_CHK: if (w_accept && (in_data != r_chk)) r_err <= 1'b1;
`endif
                default: ;
            endcase
        end
    end

    assign in_ready             = w_in_ready;
    assign busy_o               = (r_state != S_IDLE);
    assign err_o                = r_err;
    assign is_start             = r_start;
    assign ran_we_InexRecur     = r_we_ir;
    assign ran_w_addr_InexRecur = r_addr_ir;
    assign ran_w_data_InexRecur = r_data_ir;
    assign ran_we_state         = r_we_st;
    assign ran_w_addr_state     = r_addr_st;
    assign ran_w_data_state     = r_data_st;

endmodule

// File: tb/tb_accel_loader.sv
// tb_accel_loader: self-checking bench for accel_loader.
// The driver feeds whole frames and updates a frame-level model whenever a word is
// accepted. The model holds the expected writes, with the cycle each one must
// appear, and the expected levels of in_ready, busy_o, is_start and err_o. A
// negedge compare process checks the DUT against the model on every cycle.
// Build with LOAD_CHECKSUM_EN defined to add the checksum word and its tests.
module tb_accel_loader;

  localparam int R_HDR = 0, R_IR = 1, R_ST = 2, R_CHK = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        acc_done_i;
  logic        ran_we_InexRecur;
  logic [11:0] ran_w_addr_InexRecur;
  logic [31:0] ran_w_data_InexRecur;
  logic        ran_we_state;
  logic [11:0] ran_w_addr_state;
  logic [17:0] ran_w_data_state;
  logic        is_start;
  logic        busy_o;
  logic        err_o;

  accel_loader #(.ADDR_W(12), .IR_W(32), .ST_W(18)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .acc_done_i(acc_done_i),
    .ran_we_InexRecur(ran_we_InexRecur), .ran_w_addr_InexRecur(ran_w_addr_InexRecur),
    .ran_w_data_InexRecur(ran_w_data_InexRecur),
    .ran_we_state(ran_we_state), .ran_w_addr_state(ran_w_addr_state),
    .ran_w_data_state(ran_w_data_state),
    .is_start(is_start), .busy_o(busy_o), .err_o(err_o)
  );

  // ---------------- clock / cycle counter ----------------
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- model state ----------------
  typedef struct {
    int          c;
    logic [11:0] a;
    logic [31:0] d;
  } wr_t;

  wr_t ir_q[$], st_q[$];       // expected writes (cycle, addr, data)
  wr_t ir_log[$], st_log[$];   // observed writes, used by literal checks
  logic [31:0] frame_q[$];     // frame currently being sent
  bit exp_ready, exp_busy, exp_start, exp_err;
  bit chk_en = 1'b0;
  int last_acc_cyc = 0;
  int obs_start_cyc = -1;
  int n_checks = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_idle();
    exp_ready = 1'b1; exp_busy = 1'b0; exp_start = 1'b0; exp_err = 1'b0;
  endtask

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    bit e_ir, e_st;
    if (chk_en) begin
      e_ir = (ir_q.size() != 0) && (ir_q[0].c == cyc);
      chk("ir_we", 32'(ran_we_InexRecur), 32'(e_ir));
      if (e_ir) begin
        if (ran_we_InexRecur) begin
          chk("ir_addr", 32'(ran_w_addr_InexRecur), 32'(ir_q[0].a));
          chk("ir_data", ran_w_data_InexRecur, ir_q[0].d);
        end
        void'(ir_q.pop_front());
      end
      if (ran_we_InexRecur) ir_log.push_back('{cyc, ran_w_addr_InexRecur, ran_w_data_InexRecur});

      e_st = (st_q.size() != 0) && (st_q[0].c == cyc);
      chk("st_we", 32'(ran_we_state), 32'(e_st));
      if (e_st) begin
        if (ran_we_state) begin
          chk("st_addr", 32'(ran_w_addr_state), 32'(st_q[0].a));
          chk("st_data", 32'(ran_w_data_state), st_q[0].d);
        end
        void'(st_q.pop_front());
      end
      if (ran_we_state) st_log.push_back('{cyc, ran_w_addr_state, 32'(ran_w_data_state)});

      chk("in_ready", 32'(in_ready), 32'(exp_ready));
      chk("busy_o", 32'(busy_o), 32'(exp_busy));
      chk("is_start", 32'(is_start), 32'(exp_start));
      chk("err_o", 32'(err_o), 32'(exp_err));
      chk("start_with_we", 32'(is_start & (ran_we_InexRecur | ran_we_state)), 32'd0);
      if (is_start && obs_start_cyc < 0) obs_start_cyc = cyc;
    end
  end

  // ---------------- driver tasks (all start and end at posedge+#1) ----------------
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic send(input logic [31:0] w, input int role, input int idx, input bit last,
                      input bit chk_match, input int gmin, input int gmax);
    int g;
    bit got;
    g = $urandom_range(gmax, gmin);
    repeat (g) begin
      in_valid = 1'b0;
      // Completion pulses outside RUN must be ignored.
      acc_done_i = ($urandom_range(0, 3) == 0);
      step();
    end
    acc_done_i = 1'b0;
    in_valid = 1'b1;
    in_data = w;
    got = 1'b0;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      got = in_ready;
      step();
      if (got) break;
    end
    chk("accept_timeout", 32'(got), 32'd1);
    in_valid = 1'b0;
    in_data = $urandom;
    if (got) begin
      last_acc_cyc = cyc;
      case (role)
        R_HDR: begin exp_busy = 1'b1; exp_err = (w[31:12] != 0); end
        R_IR:  ir_q.push_back('{cyc, 12'(idx), w});
        R_ST: begin
          st_q.push_back('{cyc, 12'(idx), w & 32'h0003_FFFF});
          if (w[31:18] != 0) exp_err = 1'b1;
`ifndef LOAD_CHECKSUM_EN
          if (last) exp_ready = 1'b0;
`endif
        end
        default: begin
          if (chk_match) exp_ready = 1'b0;
          else begin exp_err = 1'b1; exp_busy = 1'b0; end
        end
      endcase
    end
  endtask

  // Sends frame_q (header + pairs), an optional checksum, then services the run.
  task automatic run_frame(input int gmin, input int gmax, input bit chk_good);
    int n;
    bit go;
    logic [31:0] x;
    n = int'(frame_q[0][11:0]) + 1;
    x = '0;
    go = 1'b1;
    ir_log.delete(); st_log.delete();
    obs_start_cyc = -1;
    for (int i = 0; i < 2 * n + 1; i++) begin
      if (i == 0) send(frame_q[i], R_HDR, 0, 1'b0, 1'b0, gmin, gmax);
      else send(frame_q[i], (i % 2 == 1) ? R_IR : R_ST, (i - 1) / 2, (i == 2 * n), 1'b0, gmin, gmax);
      x ^= frame_q[i];
    end
`ifdef LOAD_CHECKSUM_EN
    go = chk_good;
    send(chk_good ? x : ~x, R_CHK, 0, 1'b1, chk_good, gmin, gmax);
`endif
    if (go) begin
      step();
      exp_start = 1'b1;
      repeat ($urandom_range(0, 4)) step();
      acc_done_i = 1'b1;
      step();
      acc_done_i = 1'b0;
      exp_start = 1'b0; exp_busy = 1'b0; exp_ready = 1'b1;
      // is_start must first show in the second cycle after the final accept.
      chk("start_latency", 32'(obs_start_cyc - last_acc_cyc), 32'd1);
    end else begin
      repeat (3) step();
      chk("no_start", 32'(obs_start_cyc < 0), 32'd1);
    end
  endtask

  task automatic make_random_frame();
    int n;
    logic [31:0] h;
    n = $urandom_range(1, 8);
    h = 32'(n - 1);
    if ($urandom_range(0, 3) == 0) h = h | ({$urandom} << 12);
    frame_q.delete();
    frame_q.push_back(h);
    for (int k = 0; k < n; k++) begin
      frame_q.push_back($urandom);
      frame_q.push_back(($urandom_range(0, 4) == 0) ? $urandom : ($urandom & 32'h0003_FFFF));
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; acc_done_i = 1'b0;
    model_idle();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_is_start", 32'(is_start), 32'd0);
    chk("rst_err", 32'(err_o), 32'd0);
    chk("rst_we", 32'({ran_we_InexRecur, ran_we_state}), 32'd0);
    chk("rst_addr", 32'({ran_w_addr_InexRecur, ran_w_addr_state}), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    chk_en = 1'b1;
    step();

    // Directed N=3 frame, back-to-back words.
    frame_q = '{32'h0000_0002, 32'hA0A0_0001, 32'h1, 32'hA1A1_0002, 32'h2, 32'hA2A2_0003, 32'h3_FFFF};
    run_frame(0, 0, 1'b1);
    chk("t1_ir_count", 32'(ir_log.size()), 32'd3);
    chk("t1_st_count", 32'(st_log.size()), 32'd3);
    if (ir_log.size() == 3 && st_log.size() == 3) begin
      chk("t1_ir_addr2", 32'(ir_log[2].a), 32'd2);
      chk("t1_ir_data0", ir_log[0].d, 32'hA0A0_0001);
      chk("t1_ir_data2", ir_log[2].d, 32'hA2A2_0003);
      chk("t1_st_addr1", 32'(st_log[1].a), 32'd1);
      chk("t1_st_data2", st_log[2].d, 32'h3_FFFF);
      chk("t1_alternate", 32'(st_log[0].c - ir_log[0].c), 32'd1);
    end
    chk("t1_err", 32'(err_o), 32'd0);

    // Same frame, in_valid dropping for a cycle before every word.
    run_frame(1, 1, 1'b1);
    chk("t2_ir_count", 32'(ir_log.size()), 32'd3);
    chk("t2_st_count", 32'(st_log.size()), 32'd3);

    // Out-of-range state word: low 18 bits written, err set, run still starts.
    frame_q = '{32'h0000_0000, 32'h1234_5678, 32'h0004_0005};
    run_frame(0, 2, 1'b1);
    if (st_log.size() == 1) chk("t3_st_data", st_log[0].d, 32'h0000_0005);
    chk("t3_err_sticky", 32'(err_o), 32'd1);
    chk("t3_started", 32'(obs_start_cyc >= 0), 32'd1);

    // Reserved header bits flag an error, and the next clean header clears it.
    frame_q = '{32'h8000_0001, 32'h1, 32'h2, 32'h3, 32'h4};
    run_frame(0, 1, 1'b1);
    chk("t4_err_hdr", 32'(err_o), 32'd1);

    // Randomized frames.
    for (int f = 0; f < 8; f++) begin
      make_random_frame();
      run_frame(0, 2, ($urandom_range(0, 2) != 0));
    end

    // Reset in the middle of pair 2 of an N=3 load.
    frame_q = '{32'h0000_0002, 32'h11, 32'h22, 32'h33, 32'h44, 32'h55, 32'h66};
    send(frame_q[0], R_HDR, 0, 1'b0, 1'b0, 0, 0);
    send(frame_q[1], R_IR, 0, 1'b0, 1'b0, 0, 0);
    send(frame_q[2], R_ST, 0, 1'b0, 1'b0, 0, 0);
    send(frame_q[3], R_IR, 1, 1'b0, 1'b0, 0, 0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    model_idle();
    @(negedge clk);
    chk("t5_we_after_rst", 32'({ran_we_InexRecur, ran_we_state}), 32'd0);
    chk("t5_start_after_rst", 32'(is_start), 32'd0);
    chk("t5_ready_after_rst", 32'(in_ready), 32'd1);
    step();
    frame_q = '{32'h0000_0001, 32'hBEEF_0000, 32'h7, 32'hBEEF_0001, 32'h8};
    run_frame(0, 0, 1'b1);
    if (ir_log.size() == 2) chk("t5_restart_addr0", 32'(ir_log[0].a), 32'd0);

`ifdef LOAD_CHECKSUM_EN
    frame_q = '{32'h0000_0001, 32'hCAFE_0001, 32'h9, 32'hCAFE_0002, 32'hA};
    run_frame(0, 0, 1'b0);
    chk("t6_bad_chk_err", 32'(err_o), 32'd1);
    chk("t6_bad_chk_idle", 32'(busy_o), 32'd0);
    run_frame(0, 0, 1'b1);
    chk("t6_good_chk_err", 32'(err_o), 32'd0);
`endif

    // Full-depth frame: N=4096, must end at 0xFFF without wrapping.
    frame_q.delete();
    frame_q.push_back(32'h0000_0FFF);
    for (int k = 0; k < 4096; k++) begin
      frame_q.push_back($urandom);
      frame_q.push_back($urandom & 32'h0003_FFFF);
    end
    run_frame(0, 0, 1'b1);
    chk("t7_ir_count", 32'(ir_log.size()), 32'd4096);
    chk("t7_st_count", 32'(st_log.size()), 32'd4096);
    if (ir_log.size() == 4096 && st_log.size() == 4096) begin
      chk("t7_ir_last_addr", 32'(ir_log[4095].a), 32'hFFF);
      chk("t7_st_last_addr", 32'(st_log[4095].a), 32'hFFF);
    end
    @(negedge clk);
    chk("t7_done_start", 32'(is_start), 32'd0);
    chk("t7_done_busy", 32'(busy_o), 32'd0);
    chk("t7_done_ready", 32'(in_ready), 32'd1);

    step();
    chk("leftover_writes", 32'(ir_q.size() + st_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    chk("watchdog", 32'd1, 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
